// File: rtl/bpsk_transmitter.sv
// UART 8N1 receiver feeding a packet assembly buffer and a BPSK modulator (0,+A,0,-A carrier per symbol).
// Optional: define BPSK_TX_PREAMBLE_EN to prefix each packet with eight 1,0,1,0,... preamble symbols.
module bpsk_transmitter #(
  parameter int CLKS_PER_BIT       = 16,
  parameter int PACKET_BYTES       = 4,
  parameter int SAMPLES_PER_SYMBOL = 16,
  parameter int AMPLITUDE          = 100
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rx,
  output logic signed [7:0] signal,
  output logic              busy,
  output logic              frame_error,
  output logic              overrun
);

  localparam int PKT_BITS = PACKET_BYTES * 8;
  localparam int UCW      = $clog2(CLKS_PER_BIT);
  localparam int BCW      = $clog2(PACKET_BYTES + 1);
  localparam int SCW      = $clog2(SAMPLES_PER_SYMBOL);
  localparam int DCW      = $clog2(PKT_BITS);

  localparam logic [UCW-1:0] HALF_LAST  = UCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [UCW-1:0] BIT_LAST   = UCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] COUNT_FULL = BCW'(PACKET_BYTES);
  localparam logic [SCW-1:0] SAMP_LAST  = SCW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [DCW-1:0] DATA_LAST  = DCW'(PKT_BITS - 1);
  localparam logic signed [7:0] POS_AMP = 8'(AMPLITUDE);
  localparam logic signed [7:0] NEG_AMP = 8'(-AMPLITUDE);

  // rx_prev is one flop behind the synchronizer output so IDLE can detect a falling edge.
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

  uart_state_t    uart_state;
  logic [UCW-1:0] uart_cnt;
  logic [2:0]     uart_bit;
  logic [7:0]     rx_byte;
  logic           byte_commit;

  assign byte_commit = (uart_state == U_STOP) && (uart_cnt == BIT_LAST) && rx_sync;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uart_state  <= U_IDLE;
      uart_cnt    <= '0;
      uart_bit    <= '0;
      rx_byte     <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (uart_state)
        U_IDLE: begin
          if (rx_prev && !rx_sync) begin
            uart_state <= U_START;
            uart_cnt   <= '0;
          end
        end
        U_START: begin
          if (uart_cnt == HALF_LAST) begin
            uart_cnt   <= '0;
            uart_bit   <= '0;
            uart_state <= rx_sync ? U_IDLE : U_DATA;
          end else begin
            uart_cnt <= uart_cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (uart_cnt == BIT_LAST) begin
            uart_cnt <= '0;
            rx_byte  <= {rx_sync, rx_byte[7:1]};
            uart_bit <= uart_bit + 1'b1;
            if (uart_bit == 3'd7) uart_state <= U_STOP;
          end else begin
            uart_cnt <= uart_cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (uart_cnt == BIT_LAST) begin
            uart_cnt    <= '0;
            uart_state  <= U_IDLE;
            frame_error <= !rx_sync;
          end else begin
            uart_cnt <= uart_cnt + 1'b1;
          end
        end
        default: uart_state <= U_IDLE;
      endcase
    end
  end

`ifdef BPSK_TX_PREAMBLE_EN
  typedef enum logic [1:0] {M_IDLE, M_PREAMBLE, M_DATA} mod_state_t;
`else
  typedef enum logic [1:0] {M_IDLE, M_DATA} mod_state_t;
`endif

  mod_state_t          mod_state;
  logic [PKT_BITS-1:0] asm_buf;
  logic [BCW-1:0]      asm_count;
  logic                buf_full;
  logic                load_packet;
  logic                last_sample;
  logic [PKT_BITS-1:0] tx_shift;
  logic [SCW-1:0]      samp_cnt;
  logic [DCW-1:0]      data_cnt;
  logic                cur_bit;
  logic [1:0]          next_phase;
`ifdef BPSK_TX_PREAMBLE_EN
  logic [2:0]          pre_cnt;
`endif

  // A full buffer is taken either by an idle modulator or on the final sample, giving gapless back-to-back packets.
  assign buf_full    = (asm_count == COUNT_FULL);
  assign last_sample = (mod_state == M_DATA) && (samp_cnt == SAMP_LAST) && (data_cnt == DATA_LAST);
  assign load_packet = buf_full && ((mod_state == M_IDLE) || last_sample);
  assign next_phase  = samp_cnt[1:0] + 2'd1;

`ifdef BPSK_TX_PREAMBLE_EN
  assign cur_bit = (mod_state == M_PREAMBLE) ? ~pre_cnt[0] : tx_shift[0];
`else
  assign cur_bit = tx_shift[0];
`endif

  function automatic logic signed [7:0] carrier(input logic [1:0] phase, input logic bit_val);
    case (phase)
      2'd1:    carrier = bit_val ? POS_AMP : NEG_AMP;
      2'd3:    carrier = bit_val ? NEG_AMP : POS_AMP;
      default: carrier = '0;
    endcase
  endfunction

  // The transfer clears the count first, so a byte committed in the same cycle lands at index 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      asm_buf   <= '0;
      asm_count <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load_packet) begin
        if (byte_commit) begin
          asm_buf[7:0] <= rx_byte;
          asm_count    <= BCW'(1);
        end else begin
          asm_count <= '0;
        end
      end else if (byte_commit) begin
        if (buf_full) begin
          overrun <= 1'b1;
        end else begin
          for (int i = 0; i < PACKET_BYTES; i++) begin
            if (asm_count == BCW'(i)) asm_buf[i*8 +: 8] <= rx_byte;
          end
          asm_count <= asm_count + 1'b1;
        end
      end
    end
  end

  // signal is registered one step ahead: each cycle it takes the carrier value for the phase samp_cnt moves to.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mod_state <= M_IDLE;
      tx_shift  <= '0;
      samp_cnt  <= '0;
      data_cnt  <= '0;
      busy      <= 1'b0;
      signal    <= '0;
`ifdef BPSK_TX_PREAMBLE_EN
      pre_cnt   <= '0;
`endif
    end else if (load_packet) begin
      tx_shift <= asm_buf;
      samp_cnt <= '0;
      data_cnt <= '0;
      busy     <= 1'b1;
      signal   <= '0;
`ifdef BPSK_TX_PREAMBLE_EN
      pre_cnt   <= '0;
      mod_state <= M_PREAMBLE;
`else
      mod_state <= M_DATA;
`endif
    end else begin
      case (mod_state)
        M_IDLE: begin
          busy   <= 1'b0;
          signal <= '0;
        end
`ifdef BPSK_TX_PREAMBLE_EN
        M_PREAMBLE: begin
          signal <= carrier(next_phase, cur_bit);
          if (samp_cnt == SAMP_LAST) begin
            samp_cnt <= '0;
            pre_cnt  <= pre_cnt + 1'b1;
            if (pre_cnt == 3'd7) mod_state <= M_DATA;
          end else begin
            samp_cnt <= samp_cnt + 1'b1;
          end
        end
`endif
        M_DATA: begin
          signal <= carrier(next_phase, cur_bit);
          if (samp_cnt == SAMP_LAST) begin
            samp_cnt <= '0;
            tx_shift <= tx_shift >> 1;
            data_cnt <= data_cnt + 1'b1;
            if (data_cnt == DATA_LAST) begin
              mod_state <= M_IDLE;
              busy      <= 1'b0;
            end
          end else begin
            samp_cnt <= samp_cnt + 1'b1;
          end
        end
        default: begin
          mod_state <= M_IDLE;
          busy      <= 1'b0;
          signal    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_transmitter.sv
// Bench for bpsk_transmitter: instance A (8 samples/symbol) and instance B (64 samples/symbol, overrun case).
// A byte-level model pushes expected samples to a queue; a watcher pops them against the DUT output.
`timescale 1ns/1ps
module tb_bpsk_transmitter;
  localparam int CPB   = 16;
  localparam int PB    = 2;
  localparam int SPS_A = 8;
  localparam int SPS_B = 64;
  localparam int AMP   = 100;
`ifdef BPSK_TX_PREAMBLE_EN
  localparam int PRE_SYMS = 8;
`else
  localparam int PRE_SYMS = 0;
`endif
  localparam logic signed [7:0] P_AMP = 8'(AMP);
  localparam logic signed [7:0] N_AMP = 8'(-AMP);

  logic clock = 1'b0;
  logic rst_a_n, rst_b_n, rx_a, rx_b;
  logic signed [7:0] signal_a, signal_b;
  logic busy_a, busy_b, fe_a, fe_b, ov_a, ov_b;

  int errors = 0;
  int checks = 0;
  int fe_cnt_a = 0;
  int fe_cnt_b = 0;
  int ov_cnt_a = 0;
  int ov_cnt_b = 0;

  logic signed [7:0] exp_q[$];
  logic [7:0]        model_buf[$];
  logic [7:0]        b2b_bytes[5];

  always #5 clock = ~clock;

  bpsk_transmitter #(
    .CLKS_PER_BIT(CPB), .PACKET_BYTES(PB), .SAMPLES_PER_SYMBOL(SPS_A), .AMPLITUDE(AMP)
  ) dut_a (
    .clock(clock), .reset_n(rst_a_n), .rx(rx_a), .signal(signal_a),
    .busy(busy_a), .frame_error(fe_a), .overrun(ov_a)
  );

  bpsk_transmitter #(
    .CLKS_PER_BIT(CPB), .PACKET_BYTES(PB), .SAMPLES_PER_SYMBOL(SPS_B), .AMPLITUDE(AMP)
  ) dut_b (
    .clock(clock), .reset_n(rst_b_n), .rx(rx_b), .signal(signal_b),
    .busy(busy_b), .frame_error(fe_b), .overrun(ov_b)
  );

  // Pulse counters: a one-cycle pulse per event adds exactly one per event.
  always @(negedge clock) begin
    if (fe_a) fe_cnt_a++;
    if (fe_b) fe_cnt_b++;
    if (ov_a) ov_cnt_a++;
    if (ov_b) ov_cnt_b++;
  end

  initial begin
    #600000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction

  function automatic logic signed [7:0] signal_of(input int sel);
    return (sel != 0) ? signal_b : signal_a;
  endfunction

  task automatic drive_rx(input int sel, input logic v);
    if (sel != 0) rx_b = v;
    else rx_a = v;
  endtask

  // One 8N1 frame, LSB first, then two idle cycles.
  task automatic applyStimulus(input int sel, input logic [7:0] value, input logic stop_bit);
    drive_rx(sel, 1'b0);
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      drive_rx(sel, value[i]);
      repeat (CPB) @(negedge clock);
    end
    drive_rx(sel, stop_bit);
    repeat (CPB) @(negedge clock);
    drive_rx(sel, 1'b1);
    repeat (2) @(negedge clock);
  endtask

  // Bit 1 -> 0,+A,0,-A ; bit 0 -> 0,-A,0,+A, repeated across the symbol.
  task automatic push_symbol(input int sel, input logic b);
    int sps;
    sps = (sel != 0) ? SPS_B : SPS_A;
    for (int s = 0; s < sps; s++) begin
      case (s % 4)
        1:       exp_q.push_back(b ? P_AMP : N_AMP);
        3:       exp_q.push_back(b ? N_AMP : P_AMP);
        default: exp_q.push_back(8'sd0);
      endcase
    end
  endtask

  task automatic expect_byte(input int sel, input logic [7:0] value);
    logic [7:0] cur;
    model_buf.push_back(value);
    if (model_buf.size() == PB) begin
      for (int p = 0; p < PRE_SYMS; p++) push_symbol(sel, (p % 2) == 0);
      for (int n = 0; n < PB; n++) begin
        cur = model_buf[n];
        for (int i = 0; i < 8; i++) push_symbol(sel, cur[i]);
      end
      model_buf.delete();
    end
  endtask

  // Waits (bounded) for busy, then compares one sample per cycle until the queue drains.
  task automatic watch_packet(input int sel, input string tag);
    int waited;
    logic signed [7:0] exp_v;
    waited = 0;
    while (!busy_of(sel) && waited < 4000) begin
      @(negedge clock);
      waited++;
    end
    checkOutput({tag, "_busy_rise"}, 32'(busy_of(sel)), 1);
    if (!busy_of(sel)) begin
      exp_q.delete();
      return;
    end
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checkOutput({tag, "_busy"}, 32'(busy_of(sel)), 1);
      checkOutput({tag, "_sample"}, 32'(signal_of(sel)), 32'(exp_v));
      @(negedge clock);
    end
    checkOutput({tag, "_busy_after"}, 32'(busy_of(sel)), 0);
    checkOutput({tag, "_signal_after"}, 32'(signal_of(sel)), 0);
  endtask

  initial begin
    int fe_before;
    int ov_before;
    int seen_busy;
    int waited;

    b2b_bytes = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'hFF};
    rx_a = 1'b1;
    rx_b = 1'b1;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(negedge clock);

    $display("[TB] reset values");
    checkOutput("reset_signal_a", 32'(signal_a), 0);
    checkOutput("reset_busy_a", 32'(busy_a), 0);
    checkOutput("reset_fe_a", 32'(fe_a), 0);
    checkOutput("reset_ov_a", 32'(ov_a), 0);
    checkOutput("reset_signal_b", 32'(signal_b), 0);
    checkOutput("reset_busy_b", 32'(busy_b), 0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    repeat (4) @(negedge clock);

    $display("[TB] basic packet 0x01 0x80");
    fork
      begin
        expect_byte(0, 8'h01); applyStimulus(0, 8'h01, 1'b1);
        expect_byte(0, 8'h80); applyStimulus(0, 8'h80, 1'b1);
      end
      watch_packet(0, "basic");
    join
    repeat (10) @(negedge clock);

    $display("[TB] frame error on 0x55");
    fe_before = fe_cnt_a;
    applyStimulus(0, 8'h55, 1'b0);
    repeat (4) @(negedge clock);
    checkOutput("frame_error_pulses", fe_cnt_a - fe_before, 1);
    checkOutput("frame_error_busy", 32'(busy_a), 0);
    fork
      begin
        expect_byte(0, 8'hAA); applyStimulus(0, 8'hAA, 1'b1);
        expect_byte(0, 8'h0F); applyStimulus(0, 8'h0F, 1'b1);
      end
      watch_packet(0, "after_fe");
    join
    checkOutput("frame_error_total", fe_cnt_a - fe_before, 1);
    repeat (10) @(negedge clock);

    $display("[TB] start-bit glitch");
    fe_before = fe_cnt_a;
    seen_busy = 0;
    rx_a = 1'b0;
    repeat (4) @(negedge clock);
    rx_a = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (busy_a) seen_busy++;
    end
    checkOutput("glitch_busy_cycles", seen_busy, 0);
    checkOutput("glitch_frame_error", fe_cnt_a - fe_before, 0);
    fork
      begin
        expect_byte(0, 8'h3C); applyStimulus(0, 8'h3C, 1'b1);
        expect_byte(0, 8'hC3); applyStimulus(0, 8'hC3, 1'b1);
      end
      watch_packet(0, "after_glitch");
    join
    repeat (10) @(negedge clock);

    $display("[TB] overrun and back-to-back on 64 samples/symbol");
    ov_before = ov_cnt_b;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          if (i < 4) expect_byte(1, b2b_bytes[i]);
          applyStimulus(1, b2b_bytes[i], 1'b1);
        end
      end
      watch_packet(1, "b2b");
    join
    checkOutput("overrun_pulses", ov_cnt_b - ov_before, 1);
    checkOutput("overrun_not_on_a", ov_cnt_a, 0);
    repeat (10) @(negedge clock);

    $display("[TB] reset mid-packet");
    applyStimulus(0, 8'h12, 1'b1);
    applyStimulus(0, 8'h34, 1'b1);
    waited = 0;
    while (!busy_a && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    repeat (60) @(negedge clock);
    waited = 0;
    while (signal_a == 8'sd0 && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("midpkt_busy_before", 32'(busy_a), 1);
    #2 rst_a_n = 1'b0;
    #1;
    checkOutput("midpkt_signal_in_reset", 32'(signal_a), 0);
    checkOutput("midpkt_busy_in_reset", 32'(busy_a), 0);
    repeat (3) @(negedge clock);
    rst_a_n = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("midpkt_busy_released", 32'(busy_a), 0);
    fork
      begin
        expect_byte(0, 8'h96); applyStimulus(0, 8'h96, 1'b1);
        expect_byte(0, 8'h69); applyStimulus(0, 8'h69, 1'b1);
      end
      watch_packet(0, "after_reset");
    join
    repeat (10) @(negedge clock);

    $display("[TB] all-ones packet 0xFF 0xFF");
    fork
      begin
        expect_byte(0, 8'hFF); applyStimulus(0, 8'hFF, 1'b1);
        expect_byte(0, 8'hFF); applyStimulus(0, 8'hFF, 1'b1);
      end
      watch_packet(0, "ones");
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bpsk_transmitter.md
# bpsk_transmitter

Transmit-side counterpart of the BPSK receiver chain. Accepts bytes on a UART serial input (8N1), assembles them into fixed-size packets, and BPSK-modulates each packet bit onto a signed 8-bit carrier sample stream for the DAC/channel. Sits between the host UART and the sample output that the receiver's demodulator consumes.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit. Even, ≥ 4.
- `PACKET_BYTES`, 4: bytes per packet. ≥ 1.
- `SAMPLES_PER_SYMBOL`, 16: output samples (clock cycles) per BPSK symbol. Multiple of 4.
- `AMPLITUDE`, 100: carrier peak, 1–127.

- `clock`  in  1  system clock; one output sample per cycle.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART serial input, idle high, asynchronous to `clock`.
- `signal`  out  signed [7:0]  modulated sample stream.
- `busy`  out  1  high while a packet (or preamble) is being modulated.
- `frame_error`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte dropped because the assembly buffer is full.

## Operation
- **RX sync:** `rx` passes through a 2-flop synchronizer (both flops reset to 1).
- **UART RX FSM:** IDLE → START → DATA → STOP.
  - IDLE: synchronized falling edge → START, counter cleared.
  - START: at `CLKS_PER_BIT/2` cycles, line re-sampled. Low → DATA; high → IDLE (glitch, no error).
  - DATA: 8 bits sampled every `CLKS_PER_BIT` at mid-bit, LSB first.
  - STOP: sampled at mid-bit. High → byte committed. Low → `frame_error` pulse, byte discarded. Either way → IDLE.
- **Assembly buffer:** `PACKET_BYTES × 8` bits plus byte count. A committed byte is written at the count index; count increments.
  - When count reaches `PACKET_BYTES`, the buffer is full.
  - Full buffer + idle modulator: packet moves to the transmit shift register, count clears.
  - Full buffer + busy modulator: buffer holds its contents. Further committed bytes are dropped with an `overrun` pulse.
- **Modulator FSM:** IDLE → (PREAMBLE) → DATA → IDLE.
  - Bit order: byte 0 first, LSB first within each byte.
  - Sample index k = cycle-in-symbol mod 4.
  - Bit 1 produces 0, +A, 0, −A.
  - Bit 0 produces 0, −A, 0, +A.
  - A = `AMPLITUDE`. Values fit in signed 8 bits with no saturation logic.
  - `signal` = 0 whenever the modulator is in IDLE.
- **Simultaneous events:** a byte commit in the same cycle as the assembly→transmit transfer goes to index 0 of the freshly cleared buffer (transfer first, then write).

## Timing
- **Reset values:** `signal` = 0, `busy` = 0, `frame_error` = 0, `overrun` = 0. FSMs go to IDLE, byte count = 0.
  - Reset mid-packet takes effect asynchronously: output returns to 0 and the partial packet is lost.
- **Commit timing:** the byte is committed in the cycle the stop bit is sampled. This is ~2 cycles of synchronizer latency plus `9.5 × CLKS_PER_BIT` after the start edge.
- **Start of transmission:** the transfer happens the cycle after the buffer fills (if the modulator is idle).
  - The next cycle, `busy` = 1 and `signal` presents sample 0 of the first symbol.
- **Packet duration:** `busy` stays high for exactly N × `SAMPLES_PER_SYMBOL` cycles. N = `8 × PACKET_BYTES`, plus 8 if the preamble is enabled.
- **Back-to-back:** if the assembly buffer is full during the last sample, the next packet's first sample follows with zero gap and `busy` stays high.
  - Otherwise, the cycle after the last sample has `busy` = 0 and `signal` = 0.
- **Pulse registers:** `frame_error` and `overrun` are registered, one cycle wide, and asserted the cycle after the causing sample.

## Configuration
- `BPSK_TX_PREAMBLE_EN`
  - Defined: each packet is preceded by 8 preamble symbols 1,0,1,0,1,0,1,0 (PREAMBLE state) for receiver carrier and phase lock.
  - Undefined: the PREAMBLE state and its counter are not compiled. DATA starts directly.

## Test plan
Settings for all cases: `CLKS_PER_BIT` = 16, `PACKET_BYTES` = 2, `SAMPLES_PER_SYMBOL` = 8, `AMPLITUDE` = 100, macro undefined unless stated.

- **Basic packet:** send 0x01, 0x80.
  - `busy` high exactly 128 cycles.
  - First 16 samples: 0,100,0,−100,0,100,0,−100, then 0,−100,0,100,0,−100,0,100.
  - Last symbol is bit 1.
  - `signal` = 0 afterwards.
- **Frame error:** send 0x55 with stop bit driven low.
  - Exactly one `frame_error` pulse.
  - Byte count unchanged: a following 0xAA, 0x0F pair transmits as 0xAA, 0x0F.
- **Glitch:** `rx` low for 4 cycles, then high.
  - No byte committed, no `frame_error`, `busy` stays 0.
- **Overrun and back-to-back:** with `SAMPLES_PER_SYMBOL` = 64, send 5 bytes back-to-back.
  - Byte 5 produces one `overrun` pulse.
  - Bytes 3,4 modulate immediately after packet 1 with no gap.
  - `busy` stays high for 2048 cycles.
- **Reset mid-packet:** assert `reset_n` = 0 halfway through a packet.
  - `signal` = 0 and `busy` = 0 immediately.
  - After release, 2 new bytes form a clean packet.
- **Preamble:** with `BPSK_TX_PREAMBLE_EN` defined, send 0xFF, 0xFF.
  - `busy` high 192 cycles.
  - The first 8 symbols alternate in phase starting with bit 1; the remaining 16 are all bit 1.
